pattern_step_sequencer: RTL
===========================

// Module: pattern_step_sequencer
// PURPOSE
//  Tempo scheduler for the drum/voice datapath: counts codec LRCLK frames, advances a step index
//  through the NIOS-written pattern word, issues per-track trigger pulses and gates to the
//  audio mixer, and exports step/frame position to the sprite renderer. Sits between SoC pattern
//  PIO, the I2S frame clock and audio_manager/sprite_control.
// PARAMETERS
//  NUM_TRACKS   4    voices; pattern bit = track*NUM_STEPS + step
//  NUM_STEPS    8    steps per bar; NUM_TRACKS*NUM_STEPS == 32
//  GATE_FRAMES  2400 frames a track gate stays high after its trigger (50 ms @48 kHz)
// PORTS
//  CLK             in   1          MAX10 50 MHz system clock
//  RESET_N         in   1          synchronous, active-low reset
//  lrclk           in   1          codec LRCLK, asynchronous to CLK
//  pattern         in   32         track/step enable bits from SoC
//  frames_per_step in   16         step length in LRCLK frames
//  play            in   1          1-cycle start pulse
//  stop            in   1          1-cycle stop pulse
//  trig            out  NUM_TRACKS 1-cycle pulse per enabled track at step start
//  gate            out  NUM_TRACKS high GATE_FRAMES frames from trig
//  step            out  3          current step index
//  frame_count     out  16         frames elapsed in current step
//  playing         out  1          high in ARMED/PLAY
//  bar_tick        out  1          1-cycle pulse at each step-0 start
// BEHAVIOUR
//  - lrclk: 2-flop sync + rising-edge detect -> frame_tick (1 CLK), 3 cycles after pin edge.
//  - Reset (RESET_N=0 on CLK edge): state IDLE; all outputs 0; sync flops 0; latched regs 0.
//  - FSM: IDLE -play-> ARMED; ARMED -frame_tick-> PLAY (step 0 start); PLAY -stop-> IDLE.
//    play in PLAY -> ARMED (resync restart at step 0). play&stop same cycle: stop wins.
//  - Step start (ARMED->PLAY, or frame_count reaching len-1 on frame_tick): next cycle
//    step<=next, frame_count<=0, trig[t]<=pat_l[t*NUM_STEPS+step], bar_tick when step==0.
//  - step wraps NUM_STEPS-1 -> 0. pat_l latched from pattern at each step-0 start only;
//    mid-bar pattern writes take effect next bar. len latched from frames_per_step at every step start.
//  - len==0 treated as 1 (step per frame). frame_count increments on frame_tick only.
//  - gate[t]: set with trig[t]; per-track 12-bit frame down-counter loaded GATE_FRAMES-1;
//    cleared when counter reaches 0 on frame_tick. Retrigger while high reloads counter.
//  - stop or IDLE: trig/gate/step/frame_count/playing/bar_tick cleared next cycle.
//  - Reset mid-operation: identical to power-on reset; no partial step output.
// CONFIGURATION
//  SEQ_SWING_EN defined: adds input swing[7:0]; even steps last len+swing, odd steps
//   max(len-swing,1) frames; swing latched with len. Bar length unchanged when swing<len.
//  SEQ_SWING_EN undefined: no swing port; every step lasts len frames.
// TESTING
//  1 reset: RESET_N=0 2 cycles with play=1 -> all outputs 0, state IDLE.
//  2 pattern=32'h0000_0001, fps=4, play -> trig[0] on first frame tick; step 1 after 4 frames;
//    trig[0] again after 32 frames; bar_tick every 32 frames.
//  3 pattern=32'hFFFF_FFFF, fps=0 -> step advances every frame, trig=4'hF each frame.
//  4 write pattern=0 at step 3 -> trigs continue to end of bar, none from next step 0.
//  5 stop at step 5 frame 2 -> next cycle playing=0, step=0, gate=0; play+stop together -> IDLE.
//  6 SEQ_SWING_EN, fps=10, swing=3 -> step lengths 13,7,13,7..., bar = 80 frames.

Source files
------------

// File: rtl/pattern_step_sequencer.sv
// Pattern step sequencer: counts codec LRCLK frames, walks a step index through a latched
// pattern word and issues per-track trig/gate pulses. Define SEQ_SWING_EN for swing timing.
module pattern_step_sequencer #(
    parameter int NUM_TRACKS  = 4,
    parameter int NUM_STEPS   = 8,
    parameter int GATE_FRAMES = 2400
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic                         lrclk,
    input  logic [31:0]                  pattern,
    input  logic [15:0]                  frames_per_step,
    input  logic                         play,
    input  logic                         stop,
`ifdef SEQ_SWING_EN
    input  logic [7:0]                   swing,
`endif
    output logic [NUM_TRACKS-1:0]        trig,
    output logic [NUM_TRACKS-1:0]        gate,
    output logic [$clog2(NUM_STEPS)-1:0] step,
    output logic [15:0]                  frame_count,
    output logic                         playing,
    output logic                         bar_tick
);
    localparam int                STEP_W    = $clog2(NUM_STEPS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
    localparam logic [11:0]       GATE_LOAD = 12'(GATE_FRAMES - 1);

    typedef enum logic [1:0] { S_IDLE, S_ARMED, S_PLAY } state_t;

    state_t                state_q, state_d;
    logic                  lrclk_s1_q, lrclk_s2_q, lrclk_s3_q;
    logic                  frame_tick_q, frame_tick_d;
    logic [31:0]           pat_l_q, pat_l_d;
    logic [15:0]           len_q, len_d;
    logic [7:0]            swing_q, swing_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [16:0]           fc_q, fc_d;
    logic [NUM_TRACKS-1:0] trig_q, trig_d;
    logic [NUM_TRACKS-1:0] gate_q, gate_d;
    logic [11:0]           gcnt_q [NUM_TRACKS];
    logic [11:0]           gcnt_d [NUM_TRACKS];
    logic                  playing_q, playing_d;
    logic                  bar_tick_q, bar_tick_d;
    logic                  start;
    logic [STEP_W-1:0]     next_step;
    logic [31:0]           pat_src;
    logic [16:0]           cur_dur;
    logic [4:0]            pat_idx;

    // Even steps are stretched by swing, odd steps shortened but never below one frame.
    function automatic logic [16:0] step_dur(input logic [15:0] len, input logic [7:0] sw,
                                             input logic odd);
        logic [16:0] base;
        base = (len == 16'd0) ? 17'd1 : {1'b0, len};
        if (!odd) return base + {9'd0, sw};
        if (base > {9'd0, sw}) return base - {9'd0, sw};
        return 17'd1;
    endfunction

    assign cur_dur = step_dur(len_q, swing_q, step_q[0]);

    always_comb begin
        state_d      = state_q;
        frame_tick_d = lrclk_s2_q & ~lrclk_s3_q;
        pat_l_d      = pat_l_q;
        len_d        = len_q;
        swing_d      = swing_q;
        step_d       = step_q;
        fc_d         = fc_q;
        trig_d       = '0;
        gate_d       = gate_q;
        gcnt_d       = gcnt_q;
        bar_tick_d   = 1'b0;
        start        = 1'b0;
        next_step    = '0;
        pat_src      = pat_l_q;
        pat_idx      = '0;

        if (frame_tick_q) begin
            for (int t = 0; t < NUM_TRACKS; t++) begin
                if (gate_q[t]) begin
                    if (gcnt_q[t] == 12'd0) gate_d[t] = 1'b0;
                    else                    gcnt_d[t] = gcnt_q[t] - 12'd1;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (play && !stop) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (frame_tick_q) begin
                    state_d = S_PLAY;
                    start   = 1'b1;
                end
            end
            S_PLAY: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (play) begin
                    state_d = S_ARMED;
                    step_d  = '0;
                    fc_d    = '0;
                end else if (frame_tick_q) begin
                    if (fc_q == cur_dur - 17'd1) begin
                        start     = 1'b1;
                        next_step = (step_q == LAST_STEP) ? '0 : step_q + 1'b1;
                    end else begin
                        fc_d = fc_q + 17'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pattern is only re-read at bar boundaries so mid-bar writes land cleanly.
        if (start) begin
            step_d = next_step;
            fc_d   = '0;
            len_d  = frames_per_step;
`ifdef SEQ_SWING_EN
            swing_d = swing;
`else
            swing_d = 8'd0;
`endif
            if (next_step == '0) begin
                pat_src    = pattern;
                pat_l_d    = pattern;
                bar_tick_d = 1'b1;
            end
            for (int t = 0; t < NUM_TRACKS; t++) begin
                pat_idx   = 5'(t * NUM_STEPS) + 5'(next_step);
                trig_d[t] = pat_src[pat_idx];
                if (pat_src[pat_idx]) begin
                    gate_d[t] = 1'b1;
                    gcnt_d[t] = GATE_LOAD;
                end
            end
        end

        if (state_d == S_IDLE) begin
            step_d     = '0;
            fc_d       = '0;
            trig_d     = '0;
            gate_d     = '0;
            bar_tick_d = 1'b0;
            for (int t = 0; t < NUM_TRACKS; t++) gcnt_d[t] = 12'd0;
        end

        playing_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            lrclk_s1_q   <= 1'b0;
            lrclk_s2_q   <= 1'b0;
            lrclk_s3_q   <= 1'b0;
            frame_tick_q <= 1'b0;
            pat_l_q      <= '0;
            len_q        <= '0;
            swing_q      <= '0;
            step_q       <= '0;
            fc_q         <= '0;
            trig_q       <= '0;
            gate_q       <= '0;
            gcnt_q       <= '{default: 12'd0};
            playing_q    <= 1'b0;
            bar_tick_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lrclk_s1_q   <= lrclk;
            lrclk_s2_q   <= lrclk_s1_q;
            lrclk_s3_q   <= lrclk_s2_q;
            frame_tick_q <= frame_tick_d;
            pat_l_q      <= pat_l_d;
            len_q        <= len_d;
            swing_q      <= swing_d;
            step_q       <= step_d;
            fc_q         <= fc_d;
            trig_q       <= trig_d;
            gate_q       <= gate_d;
            gcnt_q       <= gcnt_d;
            playing_q    <= playing_d;
            bar_tick_q   <= bar_tick_d;
        end
    end

    assign trig        = trig_q;
    assign gate        = gate_q;
    assign step        = step_q;
    assign frame_count = fc_q[15:0];
    assign playing     = playing_q;
    assign bar_tick    = bar_tick_q;
endmodule
